// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_ctrl
//  Description : Direct-mapped instruction-cache controller. Looks up a
//                fetch in an external tag/valid/data RAM, refills a missing
//                line with an 8-beat read burst, and services single-line
//                invalidate requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_ctrl #(
    parameter int INDEX_SIZE    = 7,
    parameter int WORD_OFF_SIZE = 3,
    parameter int TAG_SIZE      = 30 - INDEX_SIZE - WORD_OFF_SIZE,
    parameter int LW            = 32 * (2 ** WORD_OFF_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU fetch port
    input  logic                  cpu_req,
    input  logic [31:0]           cpu_addr,
    output logic                  cpu_addr_ok,
    output logic                  cpu_data_ok,
    output logic [31:0]           cpu_rdata,
    // invalidate port
    input  logic                  inv_req,
    input  logic [INDEX_SIZE-1:0] inv_index,
    output logic                  inv_ack,
    // cache RAM
    output logic                  ram_wen,
    output logic [INDEX_SIZE-1:0] ram_a,
    output logic [INDEX_SIZE-1:0] ram_dpra,
    output logic [TAG_SIZE-1:0]   ram_d,
    output logic [LW-1:0]         ram_dina,
    output logic                  ram_w_valid,
    input  logic [TAG_SIZE-1:0]   ram_dpo,
    input  logic [LW-1:0]         ram_douta,
    input  logic                  ram_cache_valid,
    // refill read-address channel
    output logic                  arvalid,
    input  logic                  arready,
    output logic [31:0]           araddr,
    output logic [7:0]            arlen,
    // refill read-data channel
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [31:0]           rdata
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_LOOKUP = 3'd1;
    localparam logic [2:0] c_S_MISS   = 3'd2;
    localparam logic [2:0] c_S_REFILL = 3'd3;
    localparam logic [2:0] c_S_WRITE  = 3'd4;
    localparam logic [2:0] c_S_RESP   = 3'd5;
    localparam logic [2:0] c_S_INV    = 3'd6;

    localparam int                       c_WORDS     = 2 ** WORD_OFF_SIZE;
    localparam logic [WORD_OFF_SIZE-1:0] c_LAST_BEAT = '1;
    localparam logic [7:0]               c_ARLEN     = 8'(c_WORDS - 1);

    logic [2:0]               r_state;
    logic [29:0]              r_word_addr;   // latched fetch address, byte bits dropped
    logic [INDEX_SIZE-1:0]    r_inv_index;
    logic [WORD_OFF_SIZE-1:0] r_cnt;
    logic [LW-1:0]            r_line;

    logic [INDEX_SIZE-1:0]    w_cpu_index;
    logic [WORD_OFF_SIZE-1:0] w_offset;
    logic [INDEX_SIZE-1:0]    w_index;
    logic [TAG_SIZE-1:0]      w_tag;
    logic                     w_hit;
    logic [1:0]               w_unused_byte_bits;

    assign w_cpu_index        = cpu_addr[WORD_OFF_SIZE+2 +: INDEX_SIZE];
    assign w_offset           = r_word_addr[WORD_OFF_SIZE-1:0];
    assign w_index            = r_word_addr[WORD_OFF_SIZE +: INDEX_SIZE];
    assign w_tag              = r_word_addr[29 -: TAG_SIZE];
    assign w_hit              = ram_cache_valid && (ram_dpo == w_tag);
    // fetches are word aligned; the byte lane bits carry no information
    assign w_unused_byte_bits = cpu_addr[1:0];

    // State register, request latching and refill line assembly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_word_addr <= '0;
            r_inv_index <= '0;
            r_cnt       <= '0;
            r_line      <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    // invalidate wins over a simultaneous fetch
                    if (inv_req) begin
                        r_inv_index <= inv_index;
                        r_state     <= c_S_INV;
                    end else if (cpu_req) begin
                        r_word_addr <= cpu_addr[31:2];
                        r_state     <= c_S_LOOKUP;
                    end
                end
                c_S_LOOKUP: r_state <= w_hit ? c_S_IDLE : c_S_MISS;
                c_S_MISS: begin
                    if (arready) begin
                        r_cnt   <= '0;
                        r_state <= c_S_REFILL;
                    end
                end
                c_S_REFILL: begin
                    if (rvalid) begin
                        r_line[{r_cnt, 5'd0} +: 32] <= rdata;
                        r_cnt                       <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST_BEAT) begin
                            r_state <= c_S_WRITE;
                        end
                    end
                end
                c_S_WRITE: r_state <= c_S_RESP;
                c_S_RESP:  r_state <= c_S_IDLE;
                c_S_INV:   r_state <= c_S_IDLE;
                default:   r_state <= c_S_IDLE;
            endcase
        end
    end

    // Output decode from the current state; everything forced low in reset
    always_comb begin
        cpu_addr_ok = 1'b0;
        cpu_data_ok = 1'b0;
        cpu_rdata   = '0;
        inv_ack     = 1'b0;
        ram_wen     = 1'b0;
        ram_a       = '0;
        ram_dpra    = '0;
        ram_d       = '0;
        ram_dina    = '0;
        ram_w_valid = 1'b0;
        arvalid     = 1'b0;
        araddr      = '0;
        arlen       = '0;
        rready      = 1'b0;
        if (!reset) begin
            // in IDLE the RAM indices follow the incoming address so the
            // data read is already under way when the request is accepted
            if (r_state == c_S_IDLE) begin
                ram_a    = w_cpu_index;
                ram_dpra = w_cpu_index;
            end else begin
                ram_a    = w_index;
                ram_dpra = w_index;
            end
            case (r_state)
                c_S_IDLE: begin
                    cpu_addr_ok = cpu_req && !inv_req;
                end
                c_S_LOOKUP: begin
                    if (w_hit) begin
                        cpu_data_ok = 1'b1;
                        cpu_rdata   = ram_douta[{w_offset, 5'd0} +: 32];
                    end
                end
                c_S_MISS: begin
                    arvalid = 1'b1;
                    araddr  = {w_tag, w_index, {WORD_OFF_SIZE{1'b0}}, 2'b00};
                    arlen   = c_ARLEN;
                end
                c_S_REFILL: begin
                    rready = 1'b1;
                end
                c_S_WRITE: begin
                    ram_wen     = 1'b1;
                    ram_d       = w_tag;
                    ram_dina    = r_line;
                    ram_w_valid = 1'b1;
                end
                c_S_RESP: begin
                    // the fresh line is served from the buffer, not the RAM
                    cpu_data_ok = 1'b1;
                    cpu_rdata   = r_line[{w_offset, 5'd0} +: 32];
                end
                c_S_INV: begin
                    ram_wen = 1'b1;
                    ram_a   = r_inv_index;
                    inv_ack = 1'b1;
                end
                default: begin
                    cpu_addr_ok = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_ctrl
//  Description : Directed, table-driven bench for icache_ctrl with a
//                behavioural cache RAM and a scripted refill slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_ctrl;

    localparam int INDEX_SIZE    = 7;
    localparam int WORD_OFF_SIZE = 3;
    localparam int TAG_SIZE      = 20;
    localparam int LW            = 256;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cpu_req;
    logic [31:0]           cpu_addr;
    logic                  cpu_addr_ok;
    logic                  cpu_data_ok;
    logic [31:0]           cpu_rdata;
    logic                  inv_req;
    logic [INDEX_SIZE-1:0] inv_index;
    logic                  inv_ack;
    logic                  ram_wen;
    logic [INDEX_SIZE-1:0] ram_a;
    logic [INDEX_SIZE-1:0] ram_dpra;
    logic [TAG_SIZE-1:0]   ram_d;
    logic [LW-1:0]         ram_dina;
    logic                  ram_w_valid;
    logic [TAG_SIZE-1:0]   ram_dpo;
    logic [LW-1:0]         ram_douta;
    logic                  ram_cache_valid;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           araddr;
    logic [7:0]            arlen;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icache_ctrl #(
        .INDEX_SIZE   (INDEX_SIZE),
        .WORD_OFF_SIZE(WORD_OFF_SIZE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_addr       (cpu_addr),
        .cpu_addr_ok    (cpu_addr_ok),
        .cpu_data_ok    (cpu_data_ok),
        .cpu_rdata      (cpu_rdata),
        .inv_req        (inv_req),
        .inv_index      (inv_index),
        .inv_ack        (inv_ack),
        .ram_wen        (ram_wen),
        .ram_a          (ram_a),
        .ram_dpra       (ram_dpra),
        .ram_d          (ram_d),
        .ram_dina       (ram_dina),
        .ram_w_valid    (ram_w_valid),
        .ram_dpo        (ram_dpo),
        .ram_douta      (ram_douta),
        .ram_cache_valid(ram_cache_valid),
        .arvalid        (arvalid),
        .arready        (arready),
        .araddr         (araddr),
        .arlen          (arlen),
        .rvalid         (rvalid),
        .rready         (rready),
        .rdata          (rdata)
    );

    // Behavioural cache RAM: async tag/valid read, 1-cycle data read
    logic [TAG_SIZE-1:0] m_tag   [128];
    logic [LW-1:0]       m_data  [128];
    logic                m_valid [128];

    assign ram_dpo         = m_tag[ram_dpra];
    assign ram_cache_valid = m_valid[ram_dpra];

    always @(posedge clk) begin
        ram_douta <= m_data[ram_a];
        if (reset) begin
            for (int k = 0; k < 128; k++) m_valid[k] <= 1'b0;
        end else if (ram_wen) begin
            m_tag[ram_a]   <= ram_d;
            m_data[ram_a]  <= ram_dina;
            m_valid[ram_a] <= ram_w_valid;
        end
    end

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        int          ar_stall;
        int          gap;
        logic [31:0] base;
        logic [31:0] exp_araddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[5];

    // One complete fetch: accept, lookup, and on a miss the whole refill
    task automatic fetch(input vec_t v);
        logic [LW-1:0] line;
        line = '0;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = v.addr;
        #1 chk("accept_addr_ok", cpu_addr_ok, 1);
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        if (v.hit) begin
            chk("hit_data_ok", cpu_data_ok, 1);
            chk("hit_rdata", cpu_rdata, v.exp_rdata);
            chk("hit_no_arvalid", arvalid, 0);
            @(negedge clk);
            #1 chk("hit_data_ok_pulse", cpu_data_ok, 0);
            return;
        end
        chk("miss_no_data_ok", cpu_data_ok, 0);
        @(negedge clk);
        for (int s = 0; s < v.ar_stall; s++) begin
            #1 chk("ar_stall_arvalid", arvalid, 1);
            chk("ar_stall_araddr", araddr, v.exp_araddr);
            @(negedge clk);
        end
        #1 chk("arvalid", arvalid, 1);
        chk("araddr", araddr, v.exp_araddr);
        chk("arlen", arlen, 7);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int g = 0; g < v.gap; g++) begin
                #1 chk("gap_rready", rready, 1);
                @(negedge clk);
            end
            #1 chk("beat_rready", rready, 1);
            rvalid = 1'b1;
            rdata  = v.base + 32'(b);
            line[b*32 +: 32] = v.base + 32'(b);
            @(negedge clk);
            rvalid = 1'b0;
        end
        #1 chk("write_wen", ram_wen, 1);
        chk("write_w_valid", ram_w_valid, 1);
        chk("write_index", ram_a, v.addr[11:5]);
        chk("write_tag", ram_d, v.addr[31:12]);
        chk("write_line", ram_dina, line);
        chk("write_no_data_ok", cpu_data_ok, 0);
        @(negedge clk);
        #1 chk("resp_data_ok", cpu_data_ok, 1);
        chk("resp_rdata", cpu_rdata, v.exp_rdata);
        chk("resp_no_wen", ram_wen, 0);
        @(negedge clk);
        #1 chk("resp_data_ok_pulse", cpu_data_ok, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t  rv;
        logic  bad;

        //        addr         hit  stall gap base    araddr       rdata
        tbl[0] = '{32'h0000_1024, 1'b0, 0, 0, 32'hA0, 32'h0000_1020, 32'hA1};
        tbl[1] = '{32'h0000_1038, 1'b1, 0, 0, 32'h00, 32'h0000_0000, 32'hA6};
        tbl[2] = '{32'h0000_1038, 1'b0, 0, 0, 32'hB0, 32'h0000_1020, 32'hB6};
        tbl[3] = '{32'h0000_2044, 1'b0, 5, 3, 32'hD0, 32'h0000_2040, 32'hD1};
        tbl[4] = '{32'h0000_2058, 1'b1, 0, 0, 32'h00, 32'h0000_0000, 32'hD6};

        reset     = 1'b1;
        cpu_req   = 1'b1;
        cpu_addr  = 32'h0000_1024;
        inv_req   = 1'b1;
        inv_index = 7'h01;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        repeat (3) @(negedge clk);
        #1 chk("rst_addr_ok", cpu_addr_ok, 0);
        chk("rst_inv_ack", inv_ack, 0);
        chk("rst_ram_a", ram_a, 0);
        chk("rst_ram_wen", ram_wen, 0);
        chk("rst_arvalid", arvalid, 0);
        cpu_req = 1'b0;
        inv_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                // invalidate line 1, then the same fetch must miss again
                @(negedge clk);
                inv_req   = 1'b1;
                inv_index = 7'h01;
                #1 chk("inv_idle_no_ack", inv_ack, 0);
                chk("inv_idle_addr_ok", cpu_addr_ok, 0);
                @(negedge clk);
                inv_req = 1'b0;
                #1 chk("inv_ack", inv_ack, 1);
                chk("inv_wen", ram_wen, 1);
                chk("inv_w_valid", ram_w_valid, 0);
                chk("inv_ram_a", ram_a, 7'h01);
                @(negedge clk);
                #1 chk("inv_ack_pulse", inv_ack, 0);
            end
            fetch(tbl[i]);
        end

        // simultaneous fetch and invalidate: invalidate first
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_addr  = 32'h0000_1024;
        inv_req   = 1'b1;
        inv_index = 7'h05;
        #1 chk("simul_addr_ok_low", cpu_addr_ok, 0);
        @(negedge clk);
        inv_req = 1'b0;
        #1 chk("simul_inv_ack", inv_ack, 1);
        chk("simul_inv_ram_a", ram_a, 7'h05);
        chk("simul_inv_addr_ok", cpu_addr_ok, 0);
        @(negedge clk);
        #1 chk("simul_accept", cpu_addr_ok, 1);
        @(negedge clk);
        cpu_req = 1'b0;
        #1 chk("simul_hit_data_ok", cpu_data_ok, 1);
        chk("simul_hit_rdata", cpu_rdata, 32'hB1);

        // reset in the middle of a refill, after four beats
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_3068;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        #1 chk("rr_araddr", araddr, 32'h0000_3060);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1;
            rdata  = 32'hE0 + 32'(b);
            @(negedge clk);
        end
        rvalid = 1'b0;
        reset  = 1'b1;
        #1 chk("rr_rst_rready", rready, 0);
        chk("rr_rst_arvalid", arvalid, 0);
        chk("rr_rst_wen", ram_wen, 0);
        chk("rr_rst_data_ok", cpu_data_ok, 0);
        chk("rr_rst_araddr", araddr, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rr_idle_rready", rready, 0);
        bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1 if (ram_wen || cpu_data_ok || rready || arvalid) bad = 1'b1;
        end
        chk("rr_quiet_after_reset", bad, 0);
        rv = '{32'h0000_3068, 1'b0, 0, 0, 32'hC0, 32'h0000_3060, 32'hC2};
        fetch(rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter INDEX_SIZE, 7, line-index width (128 lines).
REQ-002 Parameter WORD_OFF_SIZE, 3, word-offset width (8 words/line); TAG_SIZE = 30-INDEX_SIZE-WORD_OFF_SIZE (20 at defaults); LW = 32*2**WORD_OFF_SIZE.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_req  in  1 / cpu_addr  in  32: fetch request and byte address; bits[1:0] ignored.
REQ-006 cpu_addr_ok  out  1 / cpu_data_ok  out  1 / cpu_rdata  out  32: request accepted / fetch word valid / fetch word.
REQ-007 inv_req  in  1 / inv_index  in  INDEX_SIZE / inv_ack  out  1: single-line invalidate request, index, one-cycle completion pulse.
REQ-008 ram_wen  out  1, ram_a  out  INDEX_SIZE, ram_dpra  out  INDEX_SIZE, ram_d  out  TAG_SIZE, ram_dina  out  LW, ram_w_valid  out  1: cache-RAM write enable, write/data-port index, tag-read index, write tag, write line, write valid bit.
REQ-009 ram_dpo  in  TAG_SIZE (async tag read), ram_douta  in  LW (data read, 1-cycle latency from ram_a), ram_cache_valid  in  1 (async valid read at ram_dpra).
REQ-010 arvalid out 1, arready in 1, araddr out 32, arlen out 8: refill read-address channel.
REQ-011 rvalid in 1, rready out 1, rdata in 32: refill read-data channel.

Function
REQ-012 FSM states IDLE, LOOKUP, MISS, REFILL, WRITE, RESP, INV; exactly one state per cycle.
REQ-013 Address split: offset=addr[WORD_OFF_SIZE+1:2], index=next INDEX_SIZE bits, tag=addr[31:32-TAG_SIZE].
REQ-014 IDLE: inv_req has priority -> latch inv_index, go INV, cpu_addr_ok=0; else cpu_req -> cpu_addr_ok=1 same cycle, latch cpu_addr, go LOOKUP.
REQ-015 In IDLE ram_a and ram_dpra = index of cpu_addr (combinational) so data read starts on accept; in all other states both = latched index.
REQ-016 LOOKUP: hit = ram_cache_valid && ram_dpo==latched tag; hit -> cpu_data_ok=1, cpu_rdata=ram_douta word[offset], go IDLE (hit latency 1 cycle after accept); miss -> go MISS.
REQ-017 MISS: arvalid=1, araddr={tag,index,offset zeroed,2'b00}, arlen=2**WORD_OFF_SIZE-1; held stable until arready; arvalid&&arready -> REFILL, beat counter=0.
REQ-018 REFILL: rready=1; each rvalid beat stored into line buffer word[counter], counter+1; beat with counter==2**WORD_OFF_SIZE-1 -> WRITE; rvalid gaps tolerated, no timeout.
REQ-019 WRITE: one cycle ram_wen=1, ram_d=tag, ram_dina=line buffer, ram_w_valid=1 -> RESP.
REQ-020 RESP: cpu_data_ok=1, cpu_rdata=line buffer word[offset] (not RAM) -> IDLE; miss latency = accept + 1 + AR wait + beats + 2.
REQ-021 INV: one cycle ram_wen=1, ram_w_valid=0, ram_a=inv_index, inv_ack=1 -> IDLE.
REQ-022 ram_wen asserted only in WRITE and INV; arvalid only in MISS; rready only in REFILL; cpu_addr_ok only in IDLE.
REQ-023 inv_req arriving in any non-IDLE state is held off (no ack) until IDLE; cpu_req likewise.
REQ-024 cpu_data_ok is a one-cycle pulse per accepted request; CPU must accept it, no backpressure.

Reset
REQ-025 reset high at clk edge -> state IDLE, counter 0, line buffer 0, latched address 0; all outputs 0 while reset high.
REQ-026 reset mid-MISS/REFILL abandons the burst (interconnect reset jointly); no RAM write, no cpu_data_ok issued afterwards.
REQ-027 Valid-bit clearing is owned by the cache RAM's own reset; controller issues no sweep.

Verification
REQ-028 Cold miss: fetch 0x0000_1024 -> araddr 0x0000_1020, arlen 7; beats 0xA0..0xA7 -> WRITE index 0x01 tag 0x00001, then cpu_rdata 0xA1 with cpu_data_ok.
REQ-029 Hit: after REQ-028 fetch 0x0000_1038 -> cpu_data_ok cycle after accept, rdata 0xA6, arvalid never high.
REQ-030 Invalidate: inv_req index 0x01 -> inv_ack one pulse, ram_wen=1 w_valid=0; repeat 0x0000_1038 -> miss, new burst at 0x0000_1020.
REQ-031 Stall: arready low 5 cycles, rvalid gaps of 3 between beats -> araddr/arvalid stable, line still assembled in order, correct word returned.
REQ-032 Simultaneous cpu_req and inv_req in IDLE -> INV first, cpu_addr_ok=0 that cycle, fetch accepted next cycle.
REQ-033 reset asserted after 4 REFILL beats -> IDLE next cycle, all outputs 0, no ram_wen; subsequent fetch to same address re-misses and completes.
